match_event_logger: RTL
=======================

Name: match_event_logger

Overview:
- Downstream consumer of the pattern-detector FSM output `z`.
- Turns each detection (a maximal run of z=1) into a timestamped record and buffers the records in a small FIFO.
- Presents records to the control/readout side on a valid/ready interface.
- Keeps a saturating event count and a sticky overflow flag for software.

Parameters:
- TS_W, 16: timestamp counter width.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- LEN_W, 8: run-length field width. Used only when MATCH_LOG_RUNLEN_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- z  in  1  detector output, sampled on every rising edge of clk.
- clr_ovf  in  1  single-cycle pulse that clears `overflow`.
- ev_valid  out  1  head record available.
- ev_ready  in  1  consumer accepts the head record.
- ev_ts  out  TS_W  timestamp of the head record.
- ev_len  out  LEN_W  run length of the head record; 0 when the feature is compiled out.
- ev_count  out  16  detections seen; saturates at 0xFFFF.
- overflow  out  1  sticky; set when a record is dropped because the FIFO is full.
- pending  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - All registers clear.
  - ts=0, z_q=0, FIFO empty.
  - ev_valid=0, ev_ts=0, ev_len=0, ev_count=0, overflow=0, pending=0.
  - Run FSM in IDLE.
- Timestamp:
  - ts reads 0 in the first cycle after reset.
  - ts increments by 1 every cycle and wraps modulo 2^TS_W.
- Edge detect:
  - z_q <= z every cycle.
  - Rise = z & ~z_q; fall = ~z & z_q.
  - z held high across reset release counts as a rise in the first post-reset cycle.
- Run FSM:
  - States: IDLE, RUN.
  - IDLE -> RUN on rise: latch start_ts = current ts; run_len = 1.
  - RUN stays while z=1: run_len += 1, saturating at 2^LEN_W-1.
  - RUN -> IDLE on z=0.
  - Back-to-back runs need at least one z=0 cycle between them to count as two events.
- Event count:
  - ev_count increments on every rise, saturating at 0xFFFF.
  - It counts dropped events too.
- Push timing:
  - Without the feature: push {ts, 0} at the clock edge that samples the rise.
  - With the feature: see Optional Feature.
- FIFO:
  - DEPTH entries, pointer-based, first-word-fall-through.
  - ev_valid = (pending != 0).
  - ev_ts and ev_len are driven from the head entry and stay stable while ev_valid & ~ev_ready.
  - Pop occurs when ev_valid & ev_ready.
- Latency: a record pushed at edge k (FIFO previously empty) shows ev_valid=1 in the cycle after edge k.
- Full:
  - Push and pop in the same cycle while full is accepted; pending stays at DEPTH.
  - Push with no pop while full drops the record and sets overflow.
- Empty:
  - ev_ready while empty is ignored.
  - Push and pop in the same cycle while empty is impossible, because the head is not yet valid.
- overflow:
  - Cleared by clr_ovf.
  - If clr_ovf and a new drop happen in the same cycle, set wins.
- Reset mid-operation: a partial run and all buffered records are discarded; no record is emitted.

Optional Feature:
- Macro: MATCH_LOG_RUNLEN_EN.
- Defined:
  - The record is pushed at the edge that samples the fall. No record is pushed at the rise.
  - Record contents: ev_ts = start_ts (timestamp of the first z=1 cycle); ev_len = run length in cycles, saturated.
  - A run still open is not pushed.
- Not defined:
  - Push on rise, with ev_len tied to 0.
  - start_ts and run_len are not implemented, so the FSM reduces to edge detection.

Test Plan:
- Single pulse: reset, then z=1 in the 5th cycle (ts=4) for 3 cycles.
  - Feature off: ev_valid in cycle ts=5, ev_ts=4, ev_len=0.
  - Feature on: ev_valid in cycle ts=8, ev_ts=4, ev_len=3.
  - ev_count=1.
- Back-pressure: 6 one-cycle pulses separated by single z=0 cycles, ev_ready=0.
  - pending=4, overflow=1, ev_count=6.
  - Head ev_ts equals the first pulse's timestamp and stays stable.
  - Raising ev_ready drains 4 records in order, then ev_valid=0.
- Full with simultaneous push/pop: FIFO full, ev_ready=1 in the same cycle as a new rise.
  - No drop, pending stays 4, overflow unchanged.
- Overflow clear race: clr_ovf pulsed in the same cycle as a drop -> overflow stays 1.
  - clr_ovf pulsed alone -> overflow clears to 0 the next cycle.
- Saturation and wrap, with TS_W=4, LEN_W=2:
  - Run of 6 cycles -> ev_len=3.
  - Event at ts=15, next event 2 cycles later -> ev_ts=1 (wrap).
- Reset mid-run: z high, reset asserted for 1 cycle, z kept high.
  - Nothing from before reset is emitted; ev_count=0 during reset.
  - Next event has ev_ts=0 (feature off: pushed immediately at the first post-reset cycle).

Source files
------------

// File: rtl/match_event_logger.sv
// Turns each detector run (maximal z=1 stretch) into a timestamped record queued in a small FWFT FIFO.
// Build option MATCH_LOG_RUNLEN_EN: log {start_ts, run length} when the run ends instead of {ts, 0} when it starts.
module match_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   z,
    input  logic                   clr_ovf,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [TS_W-1:0]        ev_ts,
    output logic [LEN_W-1:0]       ev_len,
    output logic [15:0]            ev_count,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [TS_W-1:0] ts;
    logic            z_q;
    logic            rise;
    logic            push, pop, full, drop, wr_en;
    logic [TS_W-1:0] push_ts;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [TS_W-1:0] mem_ts [DEPTH];

    // z_q clears on reset, so z held high through reset release reads as a fresh rise
    assign rise = z & ~z_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts  <= '0;
            z_q <= 1'b0;
        end else begin
            ts  <= ts + TS_W'(1);
            z_q <= z;
        end
    end

`ifdef MATCH_LOG_RUNLEN_EN
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [TS_W-1:0]  start_ts, start_ts_nxt;
    logic [LEN_W-1:0] run_len, run_len_nxt;
    logic [LEN_W-1:0] mem_len [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            start_ts <= '0;
            run_len  <= '0;
        end else begin
            state    <= state_nxt;
            start_ts <= start_ts_nxt;
            run_len  <= run_len_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_ts_nxt = start_ts;
        run_len_nxt  = run_len;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt    = RUN;
                    start_ts_nxt = ts;
                    run_len_nxt  = LEN_W'(1);
                end
            end
            RUN: begin
                if (z) begin
                    if (run_len != '1)
                        run_len_nxt = run_len + LEN_W'(1);
                end else begin
                    // run closed: the registered length already covers every z=1 cycle
                    state_nxt = IDLE;
                    push      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign push_ts = start_ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_len[i] <= '0;
        end else if (wr_en) begin
            mem_len[wr_ptr] <= run_len;
        end
    end

    assign ev_len = mem_len[rd_ptr];
`else
    assign push    = rise;
    assign push_ts = ts;
    assign ev_len  = '0;
`endif

    assign full     = (pending == PW'(DEPTH));
    assign ev_valid = (pending != '0);
    assign pop      = ev_valid & ev_ready;
    // a pop in the same cycle frees the slot, so only push-without-pop while full drops
    assign drop     = push & full & ~pop;
    assign wr_en    = push & ~drop;
    assign ev_ts    = mem_ts[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            ev_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem_ts[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_ts[wr_ptr] <= push_ts;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
            if (rise && ev_count != 16'hFFFF)
                ev_count <= ev_count + 16'd1;
        end
    end
endmodule
